pipeline_fetch: RTL and testbench
=================================

// Module: pipeline_fetch
// PURPOSE
//   Instruction fetch stage that feeds pipeline_decode. Owns the fetch PC and issues one
//   32-bit instruction request at a time to the instruction memory port. Buffers returned
//   instructions in a small FIFO. Presents {instruction, instruction_pc} to decode and
//   inserts the bubble encoding 90 when the FIFO is empty. Handles branch/jump redirects
//   by flushing the FIFO and discarding the stale in-flight response.
// PARAMETERS
//   ADDR_WIDTH  64     width of PC and memory address
//   DATA_WIDTH  64     datapath width; instruction width is DATA_WIDTH/2
//   RESET_PC    'h0    fetch PC loaded on reset
//   FIFO_DEPTH  2      instruction buffer entries; power of two, >=2
// PORTS
//   clk               in   1             clock; all state updates on posedge
//   reset             in   1             synchronous, active-high
//   redirect_valid    in   1             execute resolved a taken branch/jump this cycle
//   redirect_pc       in   ADDR_WIDTH    new fetch target (low 2 bits ignored, forced 0)
//   imem_req_valid    out  1             request valid
//   imem_req_addr     out  ADDR_WIDTH    request address (4-byte aligned)
//   imem_req_ready    in   1             memory accepts request this cycle
//   imem_resp_valid   in   1             response valid; in order, at most one outstanding
//   imem_resp_data    in   DATA_WIDTH/2  fetched instruction
//   decode_ready      in   1             decode 'ready'; pop FIFO head when 1 and FIFO non-empty
//   instruction       out  DATA_WIDTH/2  FIFO head, or 90 when empty
//   instruction_pc    out  ADDR_WIDTH    PC of FIFO head, or 0 when empty
// BEHAVIOUR
//   State registers: fetch_pc, req_pc (PC of outstanding request), state,
//   FIFO (rd/wr pointers + count).
//   Reset: fetch_pc=RESET_PC, state=REQ, FIFO empty, imem_req_valid=0,
//     instruction=90, instruction_pc=0.
//   Mealy outputs: imem_req_valid = (state==REQ) && count<FIFO_DEPTH && !redirect_valid;
//     imem_req_addr = fetch_pc.
//   REQ: on imem_req_valid && imem_req_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4
//     (wraps modulo 2^ADDR_WIDTH), ->WAIT.
//   WAIT: on imem_resp_valid: push {req_pc, resp_data}, ->REQ.
//     Room is guaranteed because a request issues only when count<FIFO_DEPTH.
//   DRAIN: on imem_resp_valid: drop the response, ->REQ.
//   Redirect (highest priority, any state): FIFO flushed (count=0); fetch_pc<=redirect_pc&~3.
//     REQ   -> stays REQ; no request issued that cycle.
//     WAIT  -> DRAIN if no response this cycle; if imem_resp_valid in the same cycle, drop it, ->REQ.
//     DRAIN -> stays DRAIN; same-cycle response is dropped, ->REQ.
//   Same-cycle events:
//     Flush beats push and pop; no pop is counted in a redirect cycle.
//     Push and pop in one cycle: count unchanged; legal even when count==FIFO_DEPTH-1.
//   Latency: response in cycle N is visible on instruction/instruction_pc in cycle N+1
//     (registered FIFO, no bypass). Best-case throughput is one instruction per 2 cycles
//     (REQ+WAIT) with single-cycle memory.
//   Outputs hold stable while decode_ready=0. The FIFO never overflows or underflows;
//     a pop of an empty FIFO is ignored.
//   Reset asserted mid-WAIT: state returns to REQ; the late response from the aborted
//     request is ignored because state!=WAIT/DRAIN. Memory must not return it after reset.
// CONFIGURATION
//   FETCH_STATS_EN defined: adds out ports fetch_count[63:0] and squash_count[63:0].
//     Both reset to 0. fetch_count +1 per pushed instruction. squash_count += flushed FIFO
//     count, +1 per dropped response, per redirect/DRAIN cycle. Counters wrap.
//   FETCH_STATS_EN undefined: no ports, no counter logic; behaviour otherwise identical.
// TESTING
//   1. Reset, RESET_PC='h1000, 1-cycle memory, decode_ready=1 -> requests to 1000,1004,1008;
//      decode sees pc 1000,1004,1008 in order, bubble (90) between them.
//   2. decode_ready=0 for 10 cycles -> exactly FIFO_DEPTH pushes, then imem_req_valid=0;
//      head stays pc 1000; after release, pcs 1000,1004 drain in order.
//   3. Redirect to 'h2002 while in WAIT for pc 1004; response arrives 3 cycles later ->
//      response dropped; next request addr 2000; 1004 never reaches decode.
//   4. Redirect in the same cycle as imem_resp_valid -> response dropped; FIFO empty next
//      cycle (instruction=90); next request issued the cycle after.
//   5. Push+pop in the same cycle with count=1 -> count stays 1; order preserved.
//   6. FETCH_STATS_EN: 5 fetches, redirect with 2 in FIFO + 1 in flight ->
//      fetch_count=5, squash_count=3.

Source files
------------

// File: rtl/pipeline_fetch.sv
// pipeline_fetch: instruction fetch stage feeding pipeline_decode.
// One outstanding 32-bit request at a time, responses buffered in a small FIFO,
// bubble (90) presented when the FIFO is empty, redirects flush and squash.
// Optional build macro FETCH_STATS_EN adds fetch_count / squash_count ports.
module pipeline_fetch #(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      imem_req_valid,
  output logic [ADDR_WIDTH-1:0]     imem_req_addr,
  input  logic                      imem_req_ready,
  input  logic                      imem_resp_valid,
  input  logic [DATA_WIDTH/2-1:0]   imem_resp_data,
  input  logic                      decode_ready,
  output logic [DATA_WIDTH/2-1:0]   instruction,
  output logic [ADDR_WIDTH-1:0]     instruction_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [63:0]               fetch_count,
  output logic [63:0]               squash_count
`endif
);

  localparam int unsigned IW = DATA_WIDTH / 2;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] BUBBLE = IW'(90);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [IW-1:0]         data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic                  req_fire;
  logic                  push;
  logic                  pop;

  assign imem_req_addr = fetch_pc;

  // Next-state, request handshake and FIFO push/pop decisions
  always_comb begin
    state_next     = state;
    req_fire       = 1'b0;
    push           = 1'b0;
    imem_req_valid = (state == ST_REQ) && (count < CW'(FIFO_DEPTH)) &&
                     !redirect_valid && !reset;
    pop            = decode_ready && (count != '0) && !redirect_valid;
    case (state)
      ST_REQ: begin
        req_fire = imem_req_valid && imem_req_ready;
        if (req_fire) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          state_next = imem_resp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_resp_valid) begin
          push       = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) state_next = ST_REQ;
      end
      default: state_next = ST_REQ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_REQ;
    else       state <= state_next;
  end

  // Fetch PC and PC of the outstanding request; redirect wins over advance
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~ADDR_WIDTH'(3);
    end else if (req_fire) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, written only on an accepted response
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

  // Head of FIFO toward decode, bubble when empty
  always_comb begin
    instruction    = BUBBLE;
    instruction_pc = '0;
    if (count != '0) begin
      instruction    = data_mem[rd_ptr];
      instruction_pc = pc_mem[rd_ptr];
    end
  end

`ifdef FETCH_STATS_EN
  logic drop;
  assign drop = imem_resp_valid &&
                ((state == ST_DRAIN) || ((state == ST_WAIT) && redirect_valid));

  // Fetch and squash statistics; both wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (push) fetch_count <= fetch_count + 64'd1;
      squash_count <= squash_count +
                      (redirect_valid ? 64'(count) : 64'd0) +
                      (drop ? 64'd1 : 64'd0);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: self-checking bench for pipeline_fetch with a variable-latency
// memory model and a scoreboard of instructions expected at decode.
module tb_pipeline_fetch;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;
`ifdef FETCH_STATS_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 2;
`endif
  localparam logic [AW-1:0] RST_PC = 64'h1000;
  localparam logic [IW-1:0] BUBBLE = 32'd90;

  logic          clk;
  logic          reset;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_data;
  logic          decode_ready;
  logic [IW-1:0] instruction;
  logic [AW-1:0] instruction_pc;
`ifdef FETCH_STATS_EN
  logic [63:0]   fetch_count;
  logic [63:0]   squash_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(2 * IW),
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .decode_ready   (decode_ready),
    .instruction    (instruction),
    .instruction_pc (instruction_pc)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .squash_count   (squash_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one outstanding request, latency drawn from [lat_lo, lat_hi]
  int unsigned   lat_lo = 1;
  int unsigned   lat_hi = 1;
  logic          resp_ok;
  logic [AW-1:0] resp_pc;

  initial begin : mem_model
    logic          fire;
    logic          rst_seen;
    logic [AW-1:0] faddr;
    logic          pend;
    logic          pend_squashed;
    logic [AW-1:0] pend_addr;
    int unsigned   pend_cnt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    resp_ok         = 1'b0;
    resp_pc         = '0;
    pend            = 1'b0;
    pend_squashed   = 1'b0;
    pend_addr       = '0;
    pend_cnt        = 0;
    forever begin
      @(negedge clk);
      fire     = imem_req_valid && imem_req_ready;
      faddr    = imem_req_addr;
      rst_seen = reset;
      if (redirect_valid && pend) pend_squashed = 1'b1;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (rst_seen) begin
        pend = 1'b0;
      end else begin
        if (fire) begin
          pend          = 1'b1;
          pend_squashed = 1'b0;
          pend_addr     = faddr;
          pend_cnt      = $urandom_range(lat_hi, lat_lo);
        end
        if (pend) begin
          pend_cnt = pend_cnt - 1;
          if (pend_cnt == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_addr[IW-1:0] ^ 32'hC0DE_0000;
            resp_pc         = pend_addr;
            resp_ok         = !pend_squashed;
            pend            = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard: models FIFO contents and checks decode's view every cycle
  logic [AW+IW-1:0] fifo_q[$];

  initial begin : scoreboard
    logic [IW-1:0] exp_i;
    logic [AW-1:0] exp_pc;
    forever begin
      @(negedge clk);
      if (reset) begin
        fifo_q.delete();
      end else begin
        if (fifo_q.size() == 0) begin
          exp_i  = BUBBLE;
          exp_pc = '0;
        end else begin
          exp_pc = fifo_q[0][AW+IW-1:IW];
          exp_i  = fifo_q[0][IW-1:0];
        end
        n_cmp++;
        if (instruction !== exp_i || instruction_pc !== exp_pc) begin
          n_bad++;
          $display("FAIL decode_head t=%0t: got pc=%h instr=%h, want pc=%h instr=%h",
                   $time, instruction_pc, instruction, exp_pc, exp_i);
        end
        if (redirect_valid) begin
          fifo_q.delete();
        end else begin
          if (decode_ready && fifo_q.size() != 0) void'(fifo_q.pop_front());
          if (imem_resp_valid && resp_ok) fifo_q.push_back({resp_pc, imem_resp_data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    decode_ready   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    decode_ready   = 1'b1;
    lat_lo = 1;
    lat_hi = 1;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b0 || instruction !== BUBBLE || instruction_pc !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req_valid=%b instr=%h pc=%h, want 0 %h 0",
               imem_req_valid, instruction, instruction_pc, BUBBLE);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_bad++;
      $display("FAIL reset_first_req: got valid=%b addr=%h, want 1 %h",
               imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_fetch_sequence();
    int unsigned   nfire;
    int unsigned   npc;
    int unsigned   cyc;
    logic [AW-1:0] seen [3];
    lat_lo = 1;
    lat_hi = 1;
    apply_reset();
    nfire = 0;
    npc   = 0;
    cyc   = 0;
    while ((nfire < 3 || npc < 3) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (imem_req_valid && imem_req_ready) begin
        n_cmp++;
        if (imem_req_addr !== RST_PC + AW'(4 * nfire)) begin
          n_bad++;
          $display("FAIL seq_req_addr: got %h, want %h", imem_req_addr, RST_PC + AW'(4 * nfire));
        end
        nfire++;
      end
      if (instruction !== BUBBLE && npc < 3) begin
        seen[npc] = instruction_pc;
        npc++;
      end
    end
    n_cmp++;
    if (npc < 3) begin
      n_bad++;
      $display("FAIL seq_timeout: got %0d instructions, want 3", npc);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (seen[k] !== RST_PC + AW'(4 * k)) begin
        n_bad++;
        $display("FAIL seq_decode_pc%0d: got %h, want %h", k, seen[k], RST_PC + AW'(4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned   nfire;
    int unsigned   npc;
    logic [AW-1:0] seen [2];
    lat_lo = 1;
    lat_hi = 1;
    apply_reset();
    decode_ready = 1'b0;
    nfire = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) nfire++;
    end
    n_cmp++;
    if (nfire != DEPTH) begin
      n_bad++;
      $display("FAIL bp_push_count: got %0d requests, want %0d", nfire, DEPTH);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b0 || instruction_pc !== RST_PC) begin
      n_bad++;
      $display("FAIL bp_full_hold: got req_valid=%b head_pc=%h, want 0 %h",
               imem_req_valid, instruction_pc, RST_PC);
    end
    tick();
    decode_ready = 1'b1;
    npc = 0;
    for (int c = 0; c < 8 && npc < 2; c++) begin
      @(negedge clk);
      if (instruction !== BUBBLE) begin
        seen[npc] = instruction_pc;
        npc++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (npc <= k || seen[k] !== RST_PC + AW'(4 * k)) begin
        n_bad++;
        $display("FAIL bp_drain_pc%0d: got %h (seen %0d), want %h",
                 k, seen[k], npc, RST_PC + AW'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_wait();
    int unsigned nfire;
    int unsigned cyc;
    int unsigned bad_pc;
    lat_lo = 4;
    lat_hi = 4;
    apply_reset();
    nfire = 0;
    cyc   = 0;
    while (nfire < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (imem_req_valid && imem_req_ready) nfire++;
    end
    n_cmp++;
    if (nfire < 2 || imem_req_addr !== RST_PC + AW'(4)) begin
      n_bad++;
      $display("FAIL rdw_second_req: got %0d reqs addr=%h, want 2 reqs addr %h",
               nfire, imem_req_addr, RST_PC + AW'(4));
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rdw_drain_no_req%0d: got req_valid=%b, want 0", c, imem_req_valid);
      end
    end
    n_cmp++;
    if (imem_resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rdw_late_resp: got resp_valid=%b, want 1", imem_resp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
      n_bad++;
      $display("FAIL rdw_new_req: got valid=%b addr=%h, want 1 2000", imem_req_valid, imem_req_addr);
    end
    bad_pc = 0;
    repeat (12) begin
      @(negedge clk);
      if (instruction !== BUBBLE && instruction_pc === RST_PC + AW'(4)) bad_pc++;
    end
    n_cmp++;
    if (bad_pc != 0) begin
      n_bad++;
      $display("FAIL rdw_stale_pc: got %0d cycles showing pc 1004, want 0", bad_pc);
    end
  endtask

  task automatic test_redirect_same_cycle();
    int unsigned cyc;
    lat_lo = 1;
    lat_hi = 1;
    apply_reset();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(imem_req_valid && imem_req_ready) && cyc < 20);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    @(negedge clk);
    n_cmp++;
    if (imem_resp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rsc_collide: got resp_valid=%b req_valid=%b, want 1 0",
               imem_resp_valid, imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instruction !== BUBBLE || instruction_pc !== '0) begin
      n_bad++;
      $display("FAIL rsc_fifo_empty: got instr=%h pc=%h, want %h 0", instruction, instruction_pc, BUBBLE);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000) begin
      n_bad++;
      $display("FAIL rsc_next_req: got valid=%b addr=%h, want 1 3000", imem_req_valid, imem_req_addr);
    end
    repeat (6) tick();
  endtask

  task automatic test_push_pop_same_cycle();
    int unsigned nfire;
    int unsigned cyc;
    lat_lo = 1;
    lat_hi = 1;
    apply_reset();
    decode_ready = 1'b0;
    nfire = 0;
    cyc   = 0;
    while (nfire < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (imem_req_valid && imem_req_ready) nfire++;
    end
    tick();
    decode_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_resp_valid !== 1'b1 || instruction_pc !== RST_PC) begin
      n_bad++;
      $display("FAIL pp_setup: got resp_valid=%b head_pc=%h, want 1 %h",
               imem_resp_valid, instruction_pc, RST_PC);
    end
    tick();
    decode_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (instruction_pc !== RST_PC + AW'(4) || imem_req_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pp_count_one: got head_pc=%h req_valid=%b, want %h 1",
               instruction_pc, imem_req_valid, RST_PC + AW'(4));
    end
    tick();
    decode_ready = 1'b1;
    repeat (6) tick();
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    int unsigned nfire;
    int unsigned cyc;
    lat_lo = 1;
    lat_hi = 1;
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if (fetch_count !== 64'd0 || squash_count !== 64'd0) begin
      n_bad++;
      $display("FAIL stats_reset: got fetch=%0d squash=%0d, want 0 0", fetch_count, squash_count);
    end
    nfire = (imem_req_valid && imem_req_ready) ? 1 : 0;
    cyc   = 0;
    while (nfire < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (imem_req_valid && imem_req_ready) nfire++;
    end
    tick();
    decode_ready = 1'b0;
    cyc = 0;
    while (nfire < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (imem_req_valid && imem_req_ready) nfire++;
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    tick();
    redirect_valid = 1'b0;
    decode_ready   = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fetch_count !== 64'd5 || squash_count !== 64'd3) begin
      n_bad++;
      $display("FAIL stats_counts: got fetch=%0d squash=%0d, want 5 3", fetch_count, squash_count);
    end
    repeat (4) tick();
  endtask
`endif

  task automatic test_back_to_back();
    logic [AW-1:0] exp_pc;
    lat_lo = 1;
    lat_hi = 3;
    apply_reset();
    exp_pc = RST_PC;
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      decode_ready   = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = {$urandom, $urandom};
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        n_cmp++;
        if (imem_req_addr !== exp_pc) begin
          n_bad++;
          $display("FAIL b2b_req_addr: got %h, want %h", imem_req_addr, exp_pc);
        end
        exp_pc = exp_pc + AW'(4);
      end
      if (redirect_valid) begin
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_req_in_redirect: got req_valid=%b, want 0", imem_req_valid);
        end
        exp_pc = redirect_pc & ~64'd3;
      end
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    decode_ready   = 1'b1;
    repeat (10) tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_fetch_sequence();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_push_pop_same_cycle();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
